conv_bram_1d_result_drain: RTL and testbench

Downstream neighbour of the 1-D BRAM convolution block.
- After a convolution pass, it reads the RESULT_D per-channel result RAMs in lock-step, column 0 to RESULT_W-1.
- It emits one beat per column, all channels packed, on a valid/ready stream.
- It absorbs the 1-cycle BRAM read latency and downstream backpressure with a 2-entry output buffer, so output never stalls when out_ready is held high.

---
 rtl/conv_bram_1d_result_drain.sv | 150 +++++++++++++++
 tb/tb_conv_bram_1d_result_drain.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bram_1d_result_drain.sv
// conv_bram_1d_result_drain: drains RESULT_W columns of RESULT_D result RAMs as packed beats, one beat per column.
// Latency: start accepted at edge T -> address 0 in cycle T+1 -> column 0 valid in cycle T+2; then 1 beat/cycle.
// Backpressure: 2-entry output buffer; reads pause when buffer + in-flight would exceed 2, head held stable.
module conv_bram_1d_result_drain #(
    parameter int DATA_WIDTH            = 8,
    parameter int RESULT_W              = 30,
    parameter int RESULT_D              = 4,
    parameter int RESULT_RAM_ADDR_WIDTH = (RESULT_W > 1) ? $clog2(RESULT_W) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  start_rdy,
    output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_rdaddr,
    input  logic [DATA_WIDTH*RESULT_D-1:0]        result_rddata,
    output logic [DATA_WIDTH*RESULT_D-1:0]        out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic                                  done
);

    localparam int AW = RESULT_RAM_ADDR_WIDTH;
    // Column counter must be able to hold RESULT_W itself (the "all issued" value).
    localparam int CW = $clog2(RESULT_W + 1);
    localparam int BW = DATA_WIDTH * RESULT_D;
    localparam logic [CW-1:0] LAST_COL = CW'(RESULT_W - 1);
    localparam logic [CW-1:0] END_COL  = CW'(RESULT_W);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rd_col_q, rd_col_d;
    logic [AW-1:0]   rdaddr_q, rdaddr_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;

    logic [BW-1:0]   buf_dat_q [2];
    logic [1:0]      buf_last_q;
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      cnt_q;

    logic            accept_start;
    logic            push, pop, last_pop, issue;
    logic [2:0]      occ;

    assign accept_start = (state_q == S_IDLE) && start;
    assign out_valid    = (cnt_q != 2'd0);
    assign out_data     = buf_dat_q[rd_ptr_q];
    assign out_last     = out_valid && buf_last_q[rd_ptr_q];
    assign pop          = out_valid && out_ready;
    assign last_pop     = pop && out_last;
    // The RAM returns the column addressed by the previous issue; it lands in the buffer this edge.
    assign push         = inflight_q;

    // Occupancy after this cycle's pop, counting the read still in flight.
    assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == S_RUN) && (rd_col_q < END_COL) && (occ < 3'd2);

    assign result_rdaddr = {RESULT_D{rdaddr_q}};

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one pass per accepted start, back to IDLE after the last beat leaves
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_RUN;
            S_RUN:   if (last_pop) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // FSM outputs: start handshake and end-of-pass pulse
    always_comb begin
        start_rdy = (state_q == S_IDLE);
        done      = (state_q == S_RUN) && last_pop && !reset;
    end

    // Read issue: column 0 goes out on the accepting edge so data arrives in time for T+2
    always_comb begin
        rd_col_d        = rd_col_q;
        rdaddr_d        = rdaddr_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        if (accept_start) begin
            rd_col_d        = CW'(1);
            rdaddr_d        = '0;
            inflight_d      = 1'b1;
            inflight_last_d = (RESULT_W == 1);
        end else if (issue) begin
            rd_col_d        = rd_col_q + CW'(1);
            rdaddr_d        = rd_col_q[AW-1:0];
            inflight_d      = 1'b1;
            inflight_last_d = (rd_col_q == LAST_COL);
        end
    end

    // Read-side registers: column counter, registered RAM address, in-flight tag
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_col_q        <= '0;
            rdaddr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            rd_col_q        <= rd_col_d;
            rdaddr_q        <= rdaddr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // Output buffer control: pointers, count and per-entry last flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            buf_last_q <= 2'b00;
        end else begin
            if (push) begin
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Output buffer payload; contents only matter while the entry is counted
    always_ff @(posedge clk) begin
        if (push) begin
            buf_dat_q[wr_ptr_q] <= result_rddata;
        end
    end

    // The issue rule must keep the buffer from ever receiving a push while full
    assert property (@(posedge clk) disable iff (reset) !(push && cnt_q == 2'd2));

endmodule

// File: tb/tb_conv_bram_1d_result_drain.sv
`timescale 1ns/1ps
module tb_conv_bram_1d_result_drain;

    localparam int DW = 8;
    localparam int W  = 30;
    localparam int D  = 4;
    localparam int AW = $clog2(W);
    localparam int BW = DW * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, start, start_rdy, out_valid, out_ready, out_last, done;
    logic [AW*D-1:0] result_rdaddr;
    logic [BW-1:0]   result_rddata, out_data;

    logic            start1, start_rdy1, out_valid1, out_ready1, out_last1, done1;
    logic [D-1:0]    rdaddr1;
    logic [BW-1:0]   rddata1, out_data1;

    logic [DW-1:0]   mem [W][D];
    logic [BW-1:0]   mem1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    conv_bram_1d_result_drain #(.DATA_WIDTH(DW), .RESULT_W(W), .RESULT_D(D)) dut (
        .clk(clk), .reset(reset), .start(start), .start_rdy(start_rdy),
        .result_rdaddr(result_rdaddr), .result_rddata(result_rddata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    conv_bram_1d_result_drain #(.DATA_WIDTH(DW), .RESULT_W(1), .RESULT_D(D)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .start_rdy(start_rdy1),
        .result_rdaddr(rdaddr1), .result_rddata(rddata1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_last(out_last1), .done(done1)
    );

    // RAM model: data for the registered address is available in the cycle that address is shown
    always_comb begin
        result_rddata = '0;
        for (int k = 0; k < D; k++)
            result_rddata[k*DW +: DW] = mem[int'(result_rdaddr[k*AW +: AW])][k];
    end
    assign rddata1 = mem1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BW-1:0] col_word(input int c);
        logic [BW-1:0] w;
        for (int k = 0; k < D; k++) w[k*DW +: DW] = mem[c][k];
        return w;
    endfunction

    typedef struct {
        logic [BW-1:0] dat;
        logic          last;
        int            col;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;

    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_dat;
    logic          prev_last;
    logic          pass_active = 1'b0;
    logic          first_seen = 1'b0;
    logic          chk_rdy_after_done = 1'b0;
    int            acc_cnt = 0;
    int            acc_cyc = 0;
    int            done_cyc = 0;
    int            n_passes = 0;

    // Scoreboard: record a pass at start acceptance, compare every handshake and cycle-level rules
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall         = 1'b0;
            pass_active        = 1'b0;
            first_seen         = 1'b0;
            chk_rdy_after_done = 1'b0;
        end else begin
            if (chk_rdy_after_done) begin
                checks++;
                if (start_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL start_rdy_after_done got=%b exp=1 cyc=%0d", start_rdy, cyc);
                end
                chk_rdy_after_done = 1'b0;
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_dat || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable got=%b/%h/%b exp=1/%h/%b", out_valid, out_data, out_last, prev_dat, prev_last);
                end
            end
            if (pass_active && first_seen && exp_q.size() > 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL gap out_valid=%b with %0d beats pending cyc=%0d", out_valid, exp_q.size(), cyc);
                end
            end
            if (pass_active && !first_seen && out_valid === 1'b1) begin
                first_seen = 1'b1;
                checks++;
                if (cyc != acc_cyc + 2) begin
                    errors++;
                    $display("FAIL first_beat_latency got=%0d exp=2", cyc - acc_cyc);
                end
            end
            if (pass_active) begin
                checks++;
                if (int'(result_rdaddr[AW-1:0]) > acc_cnt + 1) begin
                    errors++;
                    $display("FAIL read_ahead addr=%0d accepted=%0d", result_rdaddr[AW-1:0], acc_cnt);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got=%h last=%b", out_data, out_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    if (out_data !== mon_e.dat || out_last !== mon_e.last) begin
                        errors++;
                        $display("FAIL beat col=%0d got=%h/%b exp=%h/%b", mon_e.col, out_data, out_last, mon_e.dat, mon_e.last);
                    end
                    checks++;
                    if (done !== mon_e.last) begin
                        errors++;
                        $display("FAIL done_at_beat col=%0d got=%b exp=%b", mon_e.col, done, mon_e.last);
                    end
                    if (mon_e.last) begin
                        pass_active        = 1'b0;
                        done_cyc           = cyc;
                        chk_rdy_after_done = 1'b1;
                    end
                    acc_cnt++;
                end
                for (int k = 1; k < D; k++) begin
                    checks++;
                    if (result_rdaddr[k*AW +: AW] !== result_rdaddr[AW-1:0]) begin
                        errors++;
                        $display("FAIL addr_replica slice=%0d got=%0d exp=%0d", k, result_rdaddr[k*AW +: AW], result_rdaddr[AW-1:0]);
                    end
                end
            end else if (done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL spurious_done got=1 exp=0 cyc=%0d", cyc);
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_dat   = out_data;
            prev_last  = out_last;
            if (start === 1'b1 && start_rdy === 1'b1) begin
                for (int c = 0; c < W; c++)
                    exp_q.push_back('{dat: col_word(c), last: (c == W - 1), col: c});
                pass_active = 1'b1;
                first_seen  = 1'b0;
                acc_cnt     = 0;
                acc_cyc     = cyc;
                n_passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input bit ramp);
        for (int c = 0; c < W; c++)
            for (int k = 0; k < D; k++)
                mem[c][k] = ramp ? DW'(4 * c + k) : DW'($urandom);
    endtask

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && start_rdy === 1'b1) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d start_rdy=%b", tag, exp_q.size(), start_rdy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        start1 = 1'b0; out_ready1 = 1'b1;
        fill_mem(1'b1);
        mem1 = BW'($urandom);
        repeat (3) tick();
        @(negedge clk);
        check("rst_start_rdy", BW'(start_rdy), BW'(1));
        check("rst_rdaddr", BW'(result_rdaddr), BW'(0));
        check("rst_out_valid", BW'(out_valid), BW'(0));
        check("rst_out_last", BW'(out_last), BW'(0));
        check("rst_done", BW'(done), BW'(0));
        tick();
        reset = 1'b0;
        tick();

        // Pass with ramp data and the consumer always ready
        start = 1'b1; tick(); start = 1'b0;
        wait_idle("ramp");
        check("ramp_done_offset", BW'(done_cyc - acc_cyc), BW'(31));
        check("ramp_passes", BW'(n_passes), BW'(1));

        // Random data, random 50% backpressure
        fill_mem(1'b0);
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(exp_q.size() == 0 && start_rdy === 1'b1) && n < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL random_ready_timeout pending=%0d", exp_q.size());
        end
        out_ready = 1'b1;
        tick();

        // Consumer stalled for 20 cycles right after start
        fill_mem(1'b0);
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (19) tick();
        @(negedge clk);
        check("stall_rdaddr", BW'(result_rdaddr[AW-1:0]), BW'(1));
        check("stall_valid", BW'(out_valid), BW'(1));
        check("stall_head", out_data, col_word(0));
        check("stall_last", BW'(out_last), BW'(0));
        tick();
        out_ready = 1'b1;
        wait_idle("stall");

        // start held high through the pass: back-to-back passes
        fill_mem(1'b0);
        start = 1'b1;
        n = 0;
        while (n_passes < 5 && n < 200) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("held_restart_gap", BW'(acc_cyc - done_cyc), BW'(1));
        wait_idle("held");
        check("held_passes", BW'(n_passes), BW'(5));

        // Reset in the middle of a pass, then a clean pass
        fill_mem(1'b0);
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (acc_cnt < 10 && n < 200) begin
            tick();
            n++;
        end
        check("reset_beat_index", BW'(acc_cnt), BW'(10));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid", BW'(out_valid), BW'(0));
        check("post_rst_start_rdy", BW'(start_rdy), BW'(1));
        check("post_rst_done", BW'(done), BW'(0));
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_idle("after_reset");

        // Single-column build
        start1 = 1'b1; tick(); start1 = 1'b0;
        @(negedge clk);
        check("w1_t1_valid", BW'(out_valid1), BW'(0));
        check("w1_t1_rdaddr", BW'(rdaddr1), BW'(0));
        @(negedge clk);
        check("w1_t2_valid", BW'(out_valid1), BW'(1));
        check("w1_t2_last", BW'(out_last1), BW'(1));
        check("w1_t2_done", BW'(done1), BW'(1));
        check("w1_t2_data", out_data1, mem1);
        @(negedge clk);
        check("w1_t3_start_rdy", BW'(start_rdy1), BW'(1));
        check("w1_t3_valid", BW'(out_valid1), BW'(0));
        check("w1_t3_done", BW'(done1), BW'(0));

        tick();
        check("final_queue_empty", BW'(exp_q.size()), BW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
